// File: rtl/wb_pkg.sv
// Shared constants and queue-entry type for the in-order write-back commit unit.
package wb_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              is_load;
        logic              data_ok;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/wb_busy_decode.sv
// Folds the destination registers of all valid queue entries into a pending-write mask.
module wb_busy_decode
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]    valid,
    input  logic [REG_W-1:0]    entry_rd [DEPTH],
    output logic [NUM_REGS-1:0] busy_mask
);
    logic [NUM_REGS-1:0] entry_mask [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_mask[gi] = valid[gi] ? reg_onehot(entry_rd[gi]) : '0;
        end
    endgenerate

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask = busy_mask | entry_mask[i];
        end
        // r0 never holds a result, so it can never be a hazard.
        busy_mask[0] = 1'b0;
    end
endmodule

// File: rtl/wb_commit_unit.sv
// In-order write-back queue: ALU results are ready on entry, load results are filled
// later in load order; the head commits one register write per cycle.
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic                mem_reg_write,
    input  logic                mem_is_load,
    input  logic [REG_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]   mem_result,
    input  logic                ld_valid,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                isWB,
    output logic [REG_W-1:0]    write_reg,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err
);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    wb_entry_t           entry_reg [DEPTH];
    logic [DEPTH-1:0]    valid_reg;
    logic [AW-1:0]       head_reg;
    logic [AW-1:0]       tail_reg;
    logic [AW:0]         count_reg;
    logic [AW:0]         count_next;
    logic                iswb_reg;
    logic [REG_W-1:0]    write_reg_reg;
    logic [DATA_W-1:0]   write_data_reg;
    logic                err_reg;

    logic                accept;
    logic                alloc;
    logic                commit;
    wb_entry_t           new_entry;
    logic [AW-1:0]       scan_idx [DEPTH];
    logic [DEPTH-1:0]    scan_wait;
    logic [REG_W-1:0]    entry_rd [DEPTH];
    logic                ld_hit;
    logic [AW-1:0]       ld_ptr;

    // Ready depends only on the registered count; a same-edge commit does not free a slot.
    assign mem_ready = (count_reg < DEPTH_CNT);
    assign accept    = mem_valid && mem_ready;
    assign alloc     = accept && mem_reg_write && (mem_rd != '0);
    assign commit    = valid_reg[head_reg] && entry_reg[head_reg].data_ok;

    always_comb begin
        new_entry.rd      = mem_rd;
        new_entry.data    = mem_result;
        new_entry.is_load = mem_is_load;
        new_entry.data_ok = !mem_is_load;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_scan
            assign scan_idx[gi]  = head_reg + AW'(gi);
            assign scan_wait[gi] = valid_reg[scan_idx[gi]]
                                 && entry_reg[scan_idx[gi]].is_load
                                 && !entry_reg[scan_idx[gi]].data_ok;
            assign entry_rd[gi]  = entry_reg[gi].rd;
        end
    endgenerate

    // Load pointer: oldest waiting load, found by scanning from the youngest slot toward head.
    always_comb begin
        ld_hit = 1'b0;
        ld_ptr = head_reg;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (scan_wait[i]) begin
                ld_hit = 1'b1;
                ld_ptr = scan_idx[i];
            end
        end
    end

    assign count_next = count_reg + (AW+1)'(alloc) - (AW+1)'(commit);

    // Entry payloads carry no reset; validity alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (alloc) begin
            entry_reg[tail_reg] <= new_entry;
        end
        if (ld_valid && ld_hit) begin
            entry_reg[ld_ptr].data    <= ld_data;
            entry_reg[ld_ptr].data_ok <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg      <= '0;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            iswb_reg       <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            iswb_reg <= commit;
            if (commit) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + 1'b1;
                write_reg_reg       <= entry_reg[head_reg].rd;
                write_data_reg      <= entry_reg[head_reg].data;
            end
            if (alloc) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + 1'b1;
            end
            count_reg <= count_next;
            if (ld_valid && !ld_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    wb_busy_decode #(
        .DEPTH(DEPTH)
    ) u_busy (
        .valid    (valid_reg),
        .entry_rd (entry_rd),
        .busy_mask(busy_mask)
    );

    assign isWB       = iswb_reg;
    assign write_reg  = write_reg_reg;
    assign write_data = write_data_reg;
    assign err        = err_reg;
endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- In-order write-back commit queue between the MEM stage and the register file write port (isWB / write_reg / write_data).
- Accepts completed instructions from MEM: ALU results are ready immediately; load results arrive later and in load order on a separate return channel.
- Commits at most one register write per cycle, in program order.
- Exports a pending-write mask that the hazard unit uses to stall on RAW dependencies.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, ≥2)
- AW, 2, log2(DEPTH); pointer width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- mem_valid  in  1  MEM stage offers an instruction this cycle
- mem_ready  out  1  queue can accept; equals (count < DEPTH)
- mem_reg_write  in  1  instruction writes a GPR
- mem_is_load  in  1  result comes from the load return channel
- mem_rd  in  5  destination register
- mem_result  in  32  ALU result; ignored when mem_is_load=1
- ld_valid  in  1  load data returning (in load program order)
- ld_data  in  32  returned load data
- isWB  out  1  register-file write enable (registered)
- write_reg  out  5  register-file write index (registered)
- write_data  out  32  register-file write data (registered)
- busy_mask  out  32  bit r set if an uncommitted entry targets r (bit 0 always 0)
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0 at an edge): all entries invalid; head, tail, load pointer and count cleared; isWB=0, write_reg=0, write_data=0, err=0. busy_mask becomes 0 combinationally from the empty queue. Reset mid-operation drops all pending entries without writing them.
- Enqueue happens when mem_valid && mem_ready:
  - mem_reg_write=0 or mem_rd=0: accepted and discarded; no entry is allocated.
  - Otherwise: allocate at tail with {rd, data, is_load, data_ok}. data_ok=1 for ALU results; data_ok=0 for loads, with data filled later.
- Load return: ld_valid writes ld_data into the oldest valid entry with is_load=1 && data_ok=0 (tracked by a load pointer) and sets its data_ok.
  - If no such entry exists, the data is dropped and err is set (sticky until reset).
  - ld_valid is never back-pressured.
- Commit:
  - At each edge, if the head entry is valid and its registered data_ok=1, the head is popped and isWB=1, write_reg=rd, write_data=data are registered. Otherwise isWB=0.
  - write_reg and write_data hold their last values when isWB=0.
- Latency:
  - ALU entry enqueued at edge N is written to the register file after edge N+1, if it is at the head.
  - Load data arriving at edge M is committed after edge M+1, if it is at the head.
  - Steady-state throughput is 1 commit per cycle.
- Ordering: a younger ready entry never commits ahead of an older load still waiting for data (head-of-line blocking is intended).
- Simultaneous events:
  - Enqueue and commit in the same cycle: count is unchanged.
  - Load return targeting the head in the same edge as a commit check: that entry commits at the following edge.
  - Enqueue of a load and ld_valid in the same cycle: ld_valid binds to an older waiting load if one exists; otherwise it is an error. Same-cycle fill of the entry being enqueued is not allowed.
- Full / empty:
  - mem_ready=0 when count==DEPTH, even if a commit occurs that edge. No combinational ready-from-commit path.
  - Empty queue yields isWB=0.
- Pointers wrap modulo DEPTH; count is AW+1 bits.
- busy_mask: combinational OR over valid entries of (1 << rd). An entry's bit clears on the edge it commits, which is the same edge isWB rises.

Decomposition:
- Shared package wb_pkg:
  - constants REG_W=5, DATA_W=32, NUM_REGS=32
  - typedef wb_entry_t {rd, data, is_load, data_ok}
- One sub-module is natural: wb_busy_decode (entry array + valid vector → 32-bit busy_mask). Queue and pointers stay in the top module.

Test Plan:
- ALU chain: reset, enqueue rd=1 data=4, rd=2 data=5, rd=3 data=7 on consecutive cycles → isWB high for 3 consecutive cycles starting one edge after the first enqueue, with (1,4),(2,5),(3,7) in order; busy_mask returns to 0.
- Load blocking: enqueue load rd=4, then ALU rd=5 data=1; hold ld_valid low 3 cycles → no isWB, busy_mask=0x30. Then ld_valid with 0xDEADBEEF → commits (4,0xDEADBEEF) followed next edge by (5,1).
- Full queue: DEPTH loads pending → mem_ready=0 and mem_valid is not accepted. One ld_valid → one commit, then mem_ready=1 the following cycle.
- Discard: enqueue rd=0 data=9 and a reg_write=0 instruction → no entries allocated, isWB never asserted, busy_mask=0.
- Protocol error: ld_valid with empty queue → err=1, no isWB. err stays 1 until rst=0 for one edge, then clears to 0.
- Mid-operation reset: two pending loads, then assert rst=0 for one edge → count=0, busy_mask=0, isWB=0. Later ld_valid sets err.
